dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the shared byte-addressable data memory. It sits between the pipeline's memory stage (requester 0) and a DMA/debug port (requester 1). It grants one access per cycle, registers the granted command onto the memory port, and checks alignment and size before any access reaches memory. It returns a tagged single-cycle response to whichever requester issued the access.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width (word)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (valid && ready)
- `req0_we` / `req1_we`  in  1  1 = store, 0 = load
- `req0_addr` / `req1_addr`  in  ADDR_W  byte address
- `req0_wdata` / `req1_wdata`  in  DATA_W  store data, low bytes used for byte/half
- `req0_size` / `req1_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req0_funct3` / `req1_funct3`  in  3  load sign control (000 lb, 100 lbu, 001 lh, 101 lhu)
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle response pulse
- `rsp0_err` / `rsp1_err`  out  1  misaligned or illegal size; qualified by rsp valid
- `rsp_rdata`  out  DATA_W  load data, shared by both requesters, qualified by rspN_valid
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory byte address
- `mem_wdata`  out  DATA_W  memory store data
- `mem_size`  out  2  memory access size
- `mem_funct3`  out  3  memory load sign control
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- Grant is combinational from the valids and `last_grant`:
  - only one valid: that requester wins.
  - both valid: the requester that is not `last_grant` wins (round-robin).
  - `reqN_ready` = grantN; at most one ready is high per cycle.
- Requesters hold valid and all fields stable until ready is seen. The arbiter never drops an accepted request.
- On accept, the command is checked before it is registered:
  - Legality: size 11 is illegal.
  - Alignment: half requires addr[0]==0; word requires addr[1:0]==0.
- An illegal or misaligned command is registered as an error. `mem_we` stays 0 and memory is not written. The response carries err=1 and `rsp_rdata`=0.
- A legal command is registered into the cmd stage, which drives the `mem_*` outputs for exactly one cycle.
  - Store: `mem_we`=1 for that cycle.
  - Load: `mem_rdata` is sampled at the end of that cycle.
- Response stage:
  - `rspN_valid` pulses for one cycle for every accepted command, loads and stores alike, tagged with the issuing requester.
  - `rsp_rdata` = sampled `mem_rdata` for loads, 0 for stores.
- `last_grant` updates only on an accept.
- FSM per stage is valid/idle only. The cmd stage is IDLE or ISSUE; ISSUE lasts exactly one cycle. No backpressure on responses.

## Timing
- Accept at edge E0 → `mem_*` driven during cycle E0..E1 → store committed / load sampled at E1 → `rspN_valid` high during E1..E2.
- Latency is 2 cycles from accept to response. Throughput is one access per cycle with back-to-back accepts and no bubbles.
- Store then load to the same address on consecutive accepts: the load returns the new data, because the memory write commits at E1 and the next issue cycle follows.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_size`=0, `mem_funct3`=0.
  - `rsp0_valid`/`rsp1_valid`/`rsp0_err`/`rsp1_err`=0, `rsp_rdata`=0.
  - cmd stage IDLE.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `req*_ready`=0 while `rst_n` is low.
- Reset mid-operation: an in-flight issue is dropped (`mem_we` forced 0 asynchronously) and no response is produced.
- While the cmd stage is IDLE, `mem_*` hold 0 and `mem_we`=0.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties, and `last_grant` is unused.
- `DMEM_ARB_FIXED_PRIO_EN` undefined: round-robin as above (default).

## Structure
- Shared package `dmem_pkg`:
  - size constants `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
  - load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - the command struct type {we, addr, wdata, size, funct3, err, id}.
- One sub-module, `dmem_rr_arb2`: two-way grant with the `last_grant` flop and the fixed-priority macro switch. The alignment check, cmd stage and response stage live in the top.

## Test plan
- Reset: hold `rst_n`=0 with both valids high → all outputs 0, no ready. Release → req0 is granted first.
- Single store then load: req0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → mem_we one cycle; rsp0 load `rsp_rdata`=0xDEADBEEF, 2 cycles after its accept.
- Contention: both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1. With `DMEM_ARB_FIXED_PRIO_EN`, all 6 go to req0.
- Misalignment: req1 lw addr 0x13, then sh addr 0x21, then size 11 → three rsp1 pulses with err=1, mem_we never asserted, `rsp_rdata`=0.
- Signed loads: memory byte 0x80 at 0x40. req0 lb → 0xFFFFFF80, lbu → 0x00000080. Halfword 0x8001 at 0x42: lh → 0xFFFF8001.
- Reset mid-operation: assert `rst_n` low in the issue cycle of a store to 0x50 → mem_we drops immediately, no rsp, and a later load of 0x50 returns the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: access sizes, load
// sign-control codes, the registered command record and the legality check.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [1:0]             size;
        logic [2:0]             funct3;
        logic                   err;
        logic                   id;
    } dmem_cmd_t;

    typedef enum logic {
        CMD_IDLE  = 1'b0,
        CMD_ISSUE = 1'b1
    } cmd_state_e;

    // Size 11 is never legal; half and word must be naturally aligned.
    function automatic logic cmd_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way grant for the data-memory arbiter, round-robin on ties by default.
// Build option DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module dmem_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (valid[0])
                grant = 2'b01;
            else if (valid[1])
                grant = 2'b10;
        end
    end
`else
    logic last_grant_reg;

    // On a tie the requester that did not win the previous accept goes next.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (valid[0] && valid[1])
                grant = last_grant_reg ? 2'b01 : 2'b10;
            else
                grant = valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_reg <= 1'b1;
        else if (|grant)
            last_grant_reg <= grant[1];
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants one of two requesters per cycle, screens size and
// alignment, issues for one cycle, then returns a tagged one-cycle response.
// Build option DMEM_ARB_FIXED_PRIO_EN (see dmem_rr_arb2) selects fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [1:0]        req0_size,
    input  logic [2:0]        req0_funct3,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [1:0]        req1_size,
    input  logic [2:0]        req1_funct3,
    output logic              rsp0_valid,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        req_valid;
    logic [1:0]        grant;
    logic              accept;
    logic [1:0]        req_bad;
    dmem_cmd_t         req_cmd [2];
    dmem_cmd_t         sel_cmd;
    dmem_cmd_t         cmd_reg;
    cmd_state_e        cmd_state_reg;
    cmd_state_e        cmd_state_next;
    logic              mem_issue;
    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic              rsp_err_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic [1:0]        rsp_valid_vec;
    logic [1:0]        rsp_err_vec;

    assign req_valid  = {req1_valid, req0_valid};
    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    dmem_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_cmd[0] = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, size: req0_size,
                          funct3: req0_funct3, err: 1'b0, id: 1'b0};
    assign req_cmd[1] = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, size: req1_size,
                          funct3: req1_funct3, err: 1'b0, id: 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_bad[gi]       = cmd_misaligned(req_cmd[gi].size, req_cmd[gi].addr[1:0]);
            assign rsp_valid_vec[gi] = rsp_valid_reg && (rsp_id_reg == 1'(gi));
            assign rsp_err_vec[gi]   = rsp_valid_vec[gi] && rsp_err_reg;
        end
    endgenerate

    always_comb begin
        sel_cmd     = req_cmd[grant[1]];
        sel_cmd.err = req_bad[grant[1]];
    end

    // Erroneous commands still occupy the issue slot so their response keeps
    // the same two-cycle latency, but they never drive the memory port.
    always_comb begin
        cmd_state_next = CMD_IDLE;
        mem_issue      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_size       = '0;
        mem_funct3     = '0;
        if (accept)
            cmd_state_next = CMD_ISSUE;
        if (cmd_state_reg == CMD_ISSUE && !cmd_reg.err) begin
            mem_issue  = 1'b1;
            mem_we     = cmd_reg.we;
            mem_addr   = cmd_reg.addr;
            mem_wdata  = cmd_reg.wdata;
            mem_size   = cmd_reg.size;
            mem_funct3 = cmd_reg.funct3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_state_reg <= CMD_IDLE;
            cmd_reg       <= '0;
        end else begin
            cmd_state_reg <= cmd_state_next;
            if (accept)
                cmd_reg <= sel_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= (cmd_state_reg == CMD_ISSUE);
            rsp_id_reg    <= cmd_reg.id;
            rsp_err_reg   <= (cmd_state_reg == CMD_ISSUE) && cmd_reg.err;
            rsp_rdata_reg <= (mem_issue && !cmd_reg.we) ? mem_rdata : '0;
        end
    end

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_err   = rsp_err_vec[0];
    assign rsp1_err   = rsp_err_vec[1];
    assign rsp_rdata  = rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level model predicts grants,
// memory-port activity and responses each cycle; directed cases pin literal values.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [1:0]  req0_size, req1_size;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic [2:0]  mem_funct3;

    int checks = 0;
    int errors = 0;
    int we_seen = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_size(req0_size),
        .req0_funct3(req0_funct3),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_size(req1_size),
        .req1_funct3(req1_funct3),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp1_valid(rsp1_valid),
        .rsp1_err(rsp1_err), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- byte-addressable memory (256 bytes, little endian) ----------------
    logic [7:0] phys_mem [256];
    logic [7:0] ref_mem  [256];

    function automatic logic [31:0] load_ext(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [1:0] size, input logic [2:0] f3);
        if (size == SZ_BYTE) return f3[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
        if (size == SZ_HALF) return f3[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        return {b3, b2, b1, b0};
    endfunction

    assign mem_rdata = load_ext(phys_mem[mem_addr[7:0]], phys_mem[mem_addr[7:0] + 8'd1],
                                phys_mem[mem_addr[7:0] + 8'd2], phys_mem[mem_addr[7:0] + 8'd3],
                                mem_size, mem_funct3);

    always @(posedge clk) begin
        if (mem_we) begin
            phys_mem[mem_addr[7:0]] = mem_wdata[7:0];
            if (mem_size != SZ_BYTE) phys_mem[mem_addr[7:0] + 8'd1] = mem_wdata[15:8];
            if (mem_size == SZ_WORD) begin
                phys_mem[mem_addr[7:0] + 8'd2] = mem_wdata[23:16];
                phys_mem[mem_addr[7:0] + 8'd3] = mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) if (mem_we === 1'b1) we_seen++;

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit          v;
        bit          id;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [2:0]  f3;
        bit          err;
        logic [31:0] rdata;
    } slot_t;

    slot_t iss, rsp, nxt;
    bit    last_winner;
    bit    go, g0, g1;
    int    nbytes;

    function automatic bit is_bad(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
            chk("rst_rdata", rsp_rdata, 0);
            iss.v = 0;
            rsp.v = 0;
            last_winner = 1;
        end else begin
            go = iss.v && !iss.err;
            chk("mem_we", mem_we, go && iss.we);
            chk("mem_addr", mem_addr, go ? iss.addr : 32'h0);
            chk("mem_wdata", mem_wdata, go ? iss.wdata : 32'h0);
            chk("mem_size", mem_size, go ? iss.size : 2'b00);
            chk("mem_funct3", mem_funct3, go ? iss.f3 : 3'b000);
            chk("rsp0_valid", rsp0_valid, rsp.v && rsp.id == 0);
            chk("rsp1_valid", rsp1_valid, rsp.v && rsp.id == 1);
            chk("rsp0_err", rsp0_err, rsp.v && rsp.id == 0 && rsp.err);
            chk("rsp1_err", rsp1_err, rsp.v && rsp.id == 1 && rsp.err);
            chk("rsp_rdata", rsp_rdata, rsp.v ? rsp.rdata : 32'h0);

            // The issued access completes this cycle: loads see memory before any later store.
            nxt = iss;
            nxt.rdata = 0;
            if (go) begin
                if (iss.we) begin
                    nbytes = (iss.size == SZ_BYTE) ? 1 : (iss.size == SZ_HALF) ? 2 : 4;
                    for (int b = 0; b < nbytes; b++)
                        ref_mem[(iss.addr + b) % 256] = iss.wdata[8*b +: 8];
                end else begin
                    nxt.rdata = load_ext(ref_mem[iss.addr % 256], ref_mem[(iss.addr + 1) % 256],
                                         ref_mem[(iss.addr + 2) % 256], ref_mem[(iss.addr + 3) % 256],
                                         iss.size, iss.f3);
                end
            end
            rsp = nxt;

            g0 = 0;
            g1 = 0;
            if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                g0 = 1;
`else
                if (last_winner == 1) g0 = 1; else g1 = 1;
`endif
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
            chk("ready0", req0_ready, g0);
            chk("ready1", req1_ready, g1);

            iss.v = g0 || g1;
            if (iss.v) begin
                iss.id    = g1;
                iss.we    = g1 ? req1_we : req0_we;
                iss.addr  = g1 ? req1_addr : req0_addr;
                iss.wdata = g1 ? req1_wdata : req0_wdata;
                iss.size  = g1 ? req1_size : req0_size;
                iss.f3    = g1 ? req1_funct3 : req0_funct3;
                iss.err   = is_bad(iss.addr, iss.size);
                last_winner = g1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit id, input bit v, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic [2:0] f3);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
            req0_size = size; req0_funct3 = f3;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
            req1_size = size; req1_funct3 = f3;
        end
    endtask

    task automatic do_req(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic [2:0] f3,
                          output logic [31:0] rd, output logic er);
        bit got;
        @(posedge clk); #1;
        set_req(id, 1, we, addr, wdata, size, f3);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        @(posedge clk); #1;
        set_req(id, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("accept_seen", {31'b0, got}, 1);
        chk("rsp_latency", id ? rsp1_valid : rsp0_valid, 1);
        rd = rsp_rdata;
        er = id ? rsp1_err : rsp0_err;
        $display("txn req%0d we=%0d addr=%08h size=%0d f3=%0d -> rdata=%08h err=%0d",
                 id, we, addr, size, f3, rd, er);
    endtask

    task automatic rand_req(input bit id);
        logic [1:0]  sz;
        logic [31:0] a;
        logic [2:0]  f;
        sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a  = 32'h80 + $urandom_range(0, 31);
        if ($urandom_range(0, 3) != 0) begin
            if (sz == SZ_HALF) a[0] = 1'b0;
            if (sz == SZ_WORD) a[1:0] = 2'b00;
        end
        case (sz)
            SZ_BYTE: f = $urandom_range(0, 1) ? F3_LBU : F3_LB;
            SZ_HALF: f = $urandom_range(0, 1) ? F3_LHU : F3_LH;
            SZ_WORD: f = F3_LW;
            default: f = 3'($urandom_range(0, 7));
        endcase
        set_req(id, 1, 1'($urandom_range(0, 1)), a, $urandom, sz, f);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [31:0] rd;
    logic        er;
    int          we0;
    bit          acc0, acc1;
    bit          exp0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 8'(i * 37 + 5);
            ref_mem[i]  = 8'(i * 37 + 5);
        end
        rst_n = 1'b0;
        set_req(0, 1, 0, 32'h00, 0, SZ_WORD, F3_LW);
        set_req(1, 1, 0, 32'h04, 0, SZ_WORD, F3_LW);
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_ready", {req0_ready, req1_ready}, 2'b00);
            chk("reset_mem_we", mem_we, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: both requesters valid for six consecutive accepts.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp0 = 1;
`else
            exp0 = (i % 2 == 0);
`endif
            chk("contend_g0", req0_ready, exp0);
            chk("contend_g1", req1_ready, !exp0);
            $display("txn contention cycle %0d grant0=%0d grant1=%0d", i, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);

        // Store then load back.
        we0 = we_seen;
        do_req(0, 1, 32'h10, 32'hDEADBEEF, SZ_WORD, F3_LW, rd, er);
        chk("sw_we_cycles", we_seen - we0, 1);
        chk("sw_rdata", rd, 0);
        chk("sw_err", er, 0);
        do_req(0, 0, 32'h10, 0, SZ_WORD, F3_LW, rd, er);
        chk("lw_rdata", rd, 32'hDEADBEEF);

        // Misaligned and illegal-size accesses from requester 1.
        we0 = we_seen;
        do_req(1, 0, 32'h13, 0, SZ_WORD, F3_LW, rd, er);
        chk("mis_lw_err", er, 1);
        chk("mis_lw_rdata", rd, 0);
        do_req(1, 1, 32'h21, 32'h1234, SZ_HALF, F3_LH, rd, er);
        chk("mis_sh_err", er, 1);
        do_req(1, 0, 32'h20, 0, 2'b11, F3_LW, rd, er);
        chk("ill_size_err", er, 1);
        chk("ill_size_rdata", rd, 0);
        chk("mis_no_we", we_seen - we0, 0);

        // Sign/zero extension of sub-word loads.
        do_req(0, 1, 32'h40, 32'h00000080, SZ_BYTE, F3_LB, rd, er);
        do_req(0, 1, 32'h42, 32'h00008001, SZ_HALF, F3_LH, rd, er);
        do_req(0, 0, 32'h40, 0, SZ_BYTE, F3_LB, rd, er);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        do_req(0, 0, 32'h40, 0, SZ_BYTE, F3_LBU, rd, er);
        chk("lbu_rdata", rd, 32'h00000080);
        do_req(0, 0, 32'h42, 0, SZ_HALF, F3_LH, rd, er);
        chk("lh_rdata", rd, 32'hFFFF8001);
        do_req(0, 0, 32'h42, 0, SZ_HALF, F3_LHU, rd, er);
        chk("lhu_rdata", rd, 32'h00008001);

        // Reset during the issue cycle of a store.
        do_req(0, 1, 32'h50, 32'h11223344, SZ_WORD, F3_LW, rd, er);
        @(posedge clk); #1;
        set_req(0, 1, 1, 32'h50, 32'hCAFEF00D, SZ_WORD, F3_LW);
        @(negedge clk);
        chk("midrst_accept", req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_issue_we", mem_we, 1);
        #1 rst_n = 1'b0;
        #1 chk("midrst_we_drop", mem_we, 0);
        @(negedge clk);
        chk("midrst_no_rsp_a", rsp0_valid, 0);
        @(negedge clk);
        chk("midrst_no_rsp_b", rsp0_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(0, 0, 32'h50, 0, SZ_WORD, F3_LW, rd, er);
        chk("midrst_old_data", rd, 32'h11223344);

        // Randomized traffic; requesters hold their command until accepted.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (acc0 || !req0_valid) begin
                if ($urandom_range(0, 99) < 65) rand_req(0); else set_req(0, 0, 0, 0, 0, 0, 0);
            end
            if (acc1 || !req1_valid) begin
                if ($urandom_range(0, 99) < 65) rand_req(1); else set_req(1, 0, 0, 0, 0, 0, 0);
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
